// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Round-robin arbiter and zero-fill sequencer for one RW0 SRAM port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DEPTH   = 512,
    parameter int DATA_W  = 128,
    parameter int MASK_W  = 4,
    parameter int INIT_EN = 1
) (
    input  logic              clock,
    input  logic              resetn,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_write,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [MASK_W-1:0] a_req_wmask,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_write,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [MASK_W-1:0] b_req_wmask,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,

    output logic              init_done
);

    localparam logic [0:0]        ST_INIT    = 1'b0;
    localparam logic [0:0]        ST_ARB     = 1'b1;
    localparam logic [0:0]        ST_RESET   = (INIT_EN != 0) ? ST_INIT : ST_ARB;
    localparam logic              DONE_RESET = (INIT_EN == 0);
    localparam logic              OWNER_A    = 1'b0;
    localparam logic              OWNER_B    = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;
    logic              last_grant_q, last_grant_d;
    logic              rsp_pending_q, rsp_pending_d;
    logic              rsp_owner_q, rsp_owner_d;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_read_accept;

    // Grants are suppressed during reset so an INIT_EN=0 build stays quiet too.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (resetn && (state_q == ST_ARB)) begin
            w_grant_a = a_req_valid && (!b_req_valid || (last_grant_q == OWNER_B));
            w_grant_b = b_req_valid && (!a_req_valid || (last_grant_q == OWNER_A));
        end
    end

    assign w_read_accept = (w_grant_a && !a_req_write) || (w_grant_b && !b_req_write);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_RESET;
            init_cnt_q    <= '0;
            init_done_q   <= DONE_RESET;
            last_grant_q  <= OWNER_B;
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= OWNER_A;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            init_done_q   <= init_done_d;
            last_grant_q  <= last_grant_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_owner_q   <= rsp_owner_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        init_done_d   = init_done_q;
        last_grant_d  = last_grant_q;
        rsp_pending_d = 1'b0;
        rsp_owner_d   = rsp_owner_q;
        if (state_q == ST_INIT) begin
            // The counter parks on the last address instead of wrapping.
            if (init_cnt_q == LAST_ADDR) begin
                state_d     = ST_ARB;
                init_done_d = 1'b1;
            end else begin
                init_cnt_d  = init_cnt_q + 1'b1;
            end
        end else begin
            if (w_grant_a) begin
                last_grant_d = OWNER_A;
            end else if (w_grant_b) begin
                last_grant_d = OWNER_B;
            end
            rsp_pending_d = w_read_accept;
            if (w_read_accept) begin
                rsp_owner_d = w_grant_b ? OWNER_B : OWNER_A;
            end
        end
    end

    always_comb begin
        sram_en     = 1'b0;
        sram_wmode  = 1'b0;
        sram_addr   = '0;
        sram_wmask  = '0;
        sram_wdata  = '0;
        a_req_ready = w_grant_a;
        b_req_ready = w_grant_b;
        if (resetn) begin
            if (state_q == ST_INIT) begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_addr  = init_cnt_q;
                sram_wmask = '1;
            end else if (w_grant_a) begin
                sram_en    = 1'b1;
                sram_wmode = a_req_write;
                sram_addr  = a_req_addr;
                sram_wmask = a_req_wmask;
                sram_wdata = a_req_wdata;
            end else if (w_grant_b) begin
                sram_en    = 1'b1;
                sram_wmode = b_req_write;
                sram_addr  = b_req_addr;
                sram_wmask = b_req_wmask;
                sram_wdata = b_req_wdata;
            end
        end
    end

    // Macro read data is forwarded straight through to the tagged owner only.
    assign a_rsp_valid = rsp_pending_q && (rsp_owner_q == OWNER_A);
    assign b_rsp_valid = rsp_pending_q && (rsp_owner_q == OWNER_B);
    assign a_rsp_rdata = a_rsp_valid ? sram_rdata : '0;
    assign b_rsp_rdata = b_rsp_valid ? sram_rdata : '0;
    assign init_done   = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Scoreboard bench for sram_port_arbiter with a behavioural SRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int DW    = 128;
    localparam int MW    = 4;
    localparam int LANE  = DW / MW;

    typedef struct {
        bit          idle;
        bit          wr;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        bit          owner;
        logic [DW-1:0] data;
        int          due;
    } rsp_t;

    logic          clock = 1'b0;
    logic          resetn;
    logic          a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
    logic [AW-1:0] a_req_addr;
    logic [MW-1:0] a_req_wmask;
    logic [DW-1:0] a_req_wdata, a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
    logic [AW-1:0] b_req_addr;
    logic [MW-1:0] b_req_wmask;
    logic [DW-1:0] b_req_wdata, b_rsp_rdata;
    logic          sram_en, sram_wmode, init_done;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata, sram_rdata;

    req_t qa[$];
    req_t qb[$];
    rsp_t sb[$];
    rsp_t mon_e;

    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    bit   mon_en  = 0;
    bit   scramble = 0;
    bit   mdl_last_b = 1;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] sram    [DEPTH];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    sram_port_arbiter #(
        .ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .MASK_W(MW), .INIT_EN(1)
    ) dut (
        .clock(clock), .resetn(resetn),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
        .a_req_addr(a_req_addr), .a_req_wmask(a_req_wmask), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
        .b_req_addr(b_req_addr), .b_req_wmask(b_req_wmask), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .init_done(init_done)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old_w;
        for (int l = 0; l < MW; l++)
            if (m[l]) r[l*LANE +: LANE] = new_w[l*LANE +: LANE];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Single-port macro: 1-cycle read latency, masked writes, garbage at power-up.
    always @(posedge clock) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= rnd_word();
        end else if (sram_en) begin
            if (sram_wmode) sram[sram_addr] <= merge(sram[sram_addr], sram_wdata, sram_wmask);
            else            sram_rdata      <= sram[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t mk(input bit idle, input bit wr, input logic [AW-1:0] a,
                                input logic [MW-1:0] m, input logic [DW-1:0] d);
        req_t r;
        r.idle = idle; r.wr = wr; r.addr = a; r.mask = m; r.data = d;
        return r;
    endfunction

    // Response monitor: pops the scoreboard whenever a response shows up.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("rsp_both_valid", 256'(a_rsp_valid & b_rsp_valid), 256'd0);
            if (a_rsp_valid || b_rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 256'({a_rsp_valid, b_rsp_valid}), 256'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_latency", 256'(cyc), 256'(mon_e.due));
                    chk("rsp_owner", 256'({a_rsp_valid, b_rsp_valid}),
                        mon_e.owner ? 256'd1 : 256'd2);
                    chk("rsp_data", mon_e.owner ? 256'(b_rsp_rdata) : 256'(a_rsp_rdata),
                        256'(mon_e.data));
                    chk("rsp_other_zero", mon_e.owner ? 256'(a_rsp_rdata) : 256'(b_rsp_rdata),
                        256'd0);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                chk("rsp_missing", 256'({a_rsp_valid, b_rsp_valid}),
                    mon_e.owner ? 256'd1 : 256'd2);
            end
        end
    end

    // Fill walk: every cycle must write zeros to the next address with full mask.
    task automatic fill(input int stop_at, output int n, output int bad);
        n = 0;
        bad = 0;
        while (!init_done && n < stop_at) begin
            @(negedge clock);
            if (!(sram_en === 1'b1 && sram_wmode === 1'b1 && sram_addr === AW'(n) &&
                  sram_wmask === '1 && sram_wdata === '0 &&
                  a_req_ready === 1'b0 && b_req_ready === 1'b0))
                bad++;
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic issue(input req_t r, input bit owner);
        rsp_t e;
        chk("sram_cmd", 256'({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}),
            256'({1'b1, r.wr, r.addr, r.mask, r.data}));
        if (r.wr) begin
            ref_mem[r.addr] = merge(ref_mem[r.addr], r.data, r.mask);
        end else begin
            e.owner = owner;
            e.data  = ref_mem[r.addr];
            e.due   = cyc + 1;
            sb.push_back(e);
        end
        mdl_last_b = owner;
    endtask

    // Called at posedge+1; drives both requesters from their queues.
    task automatic run_traffic(input int budget);
        req_t ca, cb;
        bit   ha, hb, ga, gb;
        int   k;
        ha = 0; hb = 0; k = 0;
        ca = mk(1, 0, '0, '0, '0);
        cb = ca;
        while ((ha || hb || qa.size() > 0 || qb.size() > 0) && k < budget) begin
            if (!ha && qa.size() > 0) begin ca = qa.pop_front(); ha = 1; end
            if (!hb && qb.size() > 0) begin cb = qb.pop_front(); hb = 1; end
            a_req_valid = ha && !ca.idle;
            a_req_write = ca.wr; a_req_addr = ca.addr; a_req_wmask = ca.mask; a_req_wdata = ca.data;
            b_req_valid = hb && !cb.idle;
            b_req_write = cb.wr; b_req_addr = cb.addr; b_req_wmask = cb.mask; b_req_wdata = cb.data;
            @(negedge clock);
            ga = a_req_valid && (!b_req_valid || mdl_last_b);
            gb = b_req_valid && (!a_req_valid || !mdl_last_b);
            chk("a_ready", 256'(a_req_ready), 256'(ga));
            chk("b_ready", 256'(b_req_ready), 256'(gb));
            if (ga) begin
                issue(ca, 1'b0);
                ha = 0;
            end else if (gb) begin
                issue(cb, 1'b1);
                hb = 0;
            end else begin
                chk("idle_sram", 256'({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}),
                    256'd0);
            end
            if (ha && ca.idle) ha = 0;
            if (hb && cb.idle) hb = 0;
            @(posedge clock);
            #1;
            k++;
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        chk("traffic_left", 256'(qa.size() + qb.size() + int'(ha) + int'(hb)), 256'd0);
    endtask

    initial begin
        int n, bad;
        logic [DW-1:0] d;
        resetn = 1'b0;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = '0; a_req_wmask = '0; a_req_wdata = '0;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = '0; b_req_wmask = '0; b_req_wdata = '0;
        scramble = 1;
        repeat (3) @(posedge clock);
        #1 scramble = 0;
        @(negedge clock);
        chk("rst_a_ready", 256'(a_req_ready), 256'd0);
        chk("rst_b_ready", 256'(b_req_ready), 256'd0);
        chk("rst_a_rsp_valid", 256'(a_rsp_valid), 256'd0);
        chk("rst_b_rsp_valid", 256'(b_rsp_valid), 256'd0);
        chk("rst_sram_en", 256'(sram_en), 256'd0);
        chk("rst_init_done", 256'(init_done), 256'd0);
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        @(posedge clock);
        #1 resetn = 1'b1;
        mon_en = 1;

        // Abort the fill part way through with an asynchronous reset.
        fill(100, n, bad);
        chk("fill_prefix_seq", 256'(bad), 256'd0);
        resetn = 1'b0;
        a_req_valid = 1'b1;
        b_req_valid = 1'b1;
        #1;
        chk("midrst_sram_en", 256'(sram_en), 256'd0);
        chk("midrst_ready", 256'({a_req_ready, b_req_ready}), 256'd0);
        chk("midrst_init_done", 256'(init_done), 256'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
        fill(600, n, bad);
        chk("fill_cycles", 256'(n), 256'd512);
        chk("fill_seq", 256'(bad), 256'd0);
        chk("init_done_high", 256'(init_done), 256'd1);
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        mdl_last_b = 1;

        // Top address reads back as zero after the fill.
        qa.push_back(mk(0, 0, 9'h1FF, '0, '0));
        run_traffic(50);

        // Masked write then readback: lanes 0 and 2 only.
        d = {16{8'hA5}};
        qa.push_back(mk(0, 1, 9'h055, 4'b0101, d));
        qa.push_back(mk(0, 0, 9'h055, '0, '0));
        run_traffic(50);

        // Contention with distinct data so cross-delivery is visible.
        qa.push_back(mk(0, 1, 9'h010, 4'hF, rnd_word()));
        qb.push_back(mk(0, 1, 9'h020, 4'hF, rnd_word()));
        qa.push_back(mk(1, 0, '0, '0, '0));
        qb.push_back(mk(1, 0, '0, '0, '0));
        run_traffic(50);
        for (int i = 0; i < 3; i++) begin
            qa.push_back(mk(0, 0, 9'h010, '0, '0));
            qb.push_back(mk(0, 0, 9'h020, '0, '0));
        end
        run_traffic(50);

        // B alone streaming reads 0..7.
        for (int i = 0; i < 8; i++) qb.push_back(mk(0, 0, AW'(i), '0, '0));
        run_traffic(50);

        // Write-only traffic produces no responses; next read sees the data.
        qa.push_back(mk(0, 1, 9'h1FF, 4'hF, rnd_word()));
        qa.push_back(mk(1, 0, '0, '0, '0));
        qa.push_back(mk(1, 0, '0, '0, '0));
        qa.push_back(mk(0, 0, 9'h1FF, '0, '0));
        run_traffic(50);

        // Random mixed traffic on a narrow address window to provoke RAW hits.
        for (int i = 0; i < 250; i++) begin
            qa.push_back(mk($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                            AW'($urandom_range(0, 15)), MW'($urandom_range(0, 15)), rnd_word()));
            qb.push_back(mk($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                            AW'($urandom_range(0, 15)), MW'($urandom_range(0, 15)), rnd_word()));
        end
        run_traffic(2000);

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", 256'(sb.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
